// File: rtl/ili9341_init_ctrl.sv
// ILI9341 power-up sequencer.
// Requests a panel hardware reset and waits for it to finish. It then waits
// the post-reset settle time and walks the init ROM. Each ROM entry is one of:
// a command byte, a data byte, a timed delay, or the end marker. Bytes go out
// to the SPI byte writer over a valid/ready handshake.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   i_start             begin the sequence (only looked at while idle)
//   o_busy, o_done      sequence in progress / one-cycle completion pulse
//   o_reset_init_ena    one-cycle request to the reset pulse generator
//   i_resets_sent       reset pulse generator has finished its pulse
//   o_rom_addr          init ROM address
//   i_rom_data          {type[1:0], payload[DW-1:0]}, one cycle after the address
//   o_tx_valid/o_tx_data/o_tx_dc/i_tx_ready  byte handshake to the SPI writer
module ili9341_init_ctrl #(
  parameter int DW           = 8,
  parameter int ROM_DEPTH    = 64,
  parameter int RST_WAIT_CYC = 12000000,
  parameter int DELAY_UNIT   = 100000,
  parameter int AW           = $clog2(ROM_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_reset_init_ena,
  input  logic          i_resets_sent,
  output logic [AW-1:0] o_rom_addr,
  input  logic [DW+1:0] i_rom_data,
  output logic          o_tx_valid,
  output logic [DW-1:0] o_tx_data,
  output logic          o_tx_dc,
  input  logic          i_tx_ready
);

  // The counter is wide enough for either the settle time or the largest ROM
  // delay. The delay product is formed at this width.
  localparam int DLY_MAX = (2**DW - 1) * DELAY_UNIT;
  localparam int CNT_MAX = (RST_WAIT_CYC > DLY_MAX) ? RST_WAIT_CYC : DLY_MAX;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [1:0] T_CMD  = 2'b00;
  localparam logic [1:0] T_DATA = 2'b01;
  localparam logic [1:0] T_DLY  = 2'b10;

  typedef enum logic [3:0] {
    IDLE, RST_REQ, RST_WAIT, RST_DLY, FETCH, DECODE, SEND, WAIT, NEXT, DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  logic [1:0]    rom_type;
  logic [DW-1:0] rom_payload;
  assign rom_type    = i_rom_data[DW+1:DW];
  assign rom_payload = i_rom_data[DW-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      cnt              <= '0;
      o_busy           <= 1'b0;
      o_done           <= 1'b0;
      o_reset_init_ena <= 1'b0;
      o_rom_addr       <= '0;
      o_tx_valid       <= 1'b0;
      o_tx_data        <= '0;
      o_tx_dc          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            o_busy           <= 1'b1;
            o_reset_init_ena <= 1'b1;
            state            <= RST_REQ;
          end
        end
        RST_REQ: begin
          o_reset_init_ena <= 1'b0;
          state            <= RST_WAIT;
        end
        RST_WAIT: begin
          if (i_resets_sent) begin
            cnt   <= CW'(RST_WAIT_CYC - 1);
            state <= RST_DLY;
          end
        end
        // The dwell is RST_WAIT_CYC cycles, including the cycle that reaches zero.
        RST_DLY: begin
          if (cnt == '0) begin
            o_rom_addr <= '0;
            state      <= FETCH;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        // The address is held here so that the synchronous ROM can produce the entry.
        FETCH: state <= DECODE;
        DECODE: begin
          case (rom_type)
            T_CMD, T_DATA: begin
              o_tx_data  <= rom_payload;
              o_tx_dc    <= rom_type[0];
              o_tx_valid <= 1'b1;
              state      <= SEND;
            end
            T_DLY: begin
              if (rom_payload != '0) begin
                cnt   <= CW'(rom_payload) * CW'(DELAY_UNIT) - CW'(1);
                state <= WAIT;
              end else begin
                state <= NEXT;
              end
            end
            default: begin
              o_done <= 1'b1;
              state  <= DONE;
            end
          endcase
        end
        SEND: begin
          if (i_tx_ready) begin
            o_tx_valid <= 1'b0;
            state      <= NEXT;
          end
        end
        WAIT: begin
          if (cnt == '0) state <= NEXT;
          else           cnt   <= cnt - CW'(1);
        end
        // The last ROM slot ends the sequence even when it holds no END marker.
        NEXT: begin
          if (o_rom_addr == AW'(ROM_DEPTH - 1)) begin
            o_done <= 1'b1;
            state  <= DONE;
          end else begin
            o_rom_addr <= o_rom_addr + AW'(1);
            state      <= FETCH;
          end
        end
        DONE: begin
          o_done <= 1'b0;
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ili9341_init_ctrl.sv
// Testbench for ili9341_init_ctrl. A ROM-level reference model turns each init
// ROM into a list of expected events: each byte with its dc flag, plus the done
// pulse. Each event carries its cycle offset from the previous anchor. The
// first anchor is the cycle in which i_resets_sent is returned. After that, the
// anchor is the cycle in which the previous byte was accepted. A monitor pops
// and compares events as the DUT presents them.
module tb_ili9341_init_ctrl;
  localparam int DW  = 8;
  localparam int DEP = 8;
  localparam int RWC = 20;
  localparam int DU  = 4;
  localparam int AW  = 3;

  logic          clk, rst, i_start, i_resets_sent, i_tx_ready;
  logic          o_busy, o_done, o_reset_init_ena, o_tx_valid, o_tx_dc;
  logic [AW-1:0] o_rom_addr;
  logic [DW+1:0] i_rom_data;
  logic [DW-1:0] o_tx_data;

  ili9341_init_ctrl #(.DW(DW), .ROM_DEPTH(DEP), .RST_WAIT_CYC(RWC), .DELAY_UNIT(DU)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .o_busy(o_busy), .o_done(o_done),
    .o_reset_init_ena(o_reset_init_ena), .i_resets_sent(i_resets_sent),
    .o_rom_addr(o_rom_addr), .i_rom_data(i_rom_data), .o_tx_valid(o_tx_valid),
    .o_tx_data(o_tx_data), .o_tx_dc(o_tx_dc), .i_tx_ready(i_tx_ready)
  );

  initial begin clk = 0; forever #5 clk = ~clk; end

  // Synchronous init ROM with a one-cycle read latency.
  logic [DW+1:0] rom [DEP];
  always @(posedge clk) i_rom_data <= rom[o_rom_addr];

  typedef struct { bit is_done; int data; int dc; int off; } ev_t;
  ev_t q[$];

  int passed = 0, total = 0;
  int ena_cnt = 0, stalls = 0;
  int cyc_d = 0, rdy_low_until = 0, rs_timer = 0;
  bit rnd_rdy = 0, rdy_zero = 0, stray_rs = 0;

  function automatic void chk(string n, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", n, act, exp);
  endfunction

  // Reference model. It is computed entry by entry from the sequencing rules:
  // FETCH, DECODE, then SEND/WAIT, then NEXT.
  task automatic model_push();
    int f, n, t, p;
    ev_t e;
    f = 1 + RWC;   // the first FETCH follows RWC settle cycles after resets_sent
    for (int a = 0; a < DEP; a++) begin
      t = int'(rom[a][DW+1:DW]);
      p = int'(rom[a][DW-1:0]);
      if (t == 3) begin
        e = '{1, 0, 0, f + 2}; q.push_back(e); return;
      end
      if (t < 2) begin
        e = '{0, p, t, f + 2}; q.push_back(e);
        n = 1;   // NEXT follows the acceptance cycle
      end else begin
        n = f + 2 + p * DU;
      end
      if (a == DEP - 1) begin
        e = '{1, 0, 0, n + 1}; q.push_back(e); return;
      end
      f = n + 1;
    end
  endtask

  // Input driver: returns resets_sent 3 cycles after each request, and drives
  // tx_ready.
  initial begin
    i_resets_sent = 0; i_tx_ready = 1;
    forever begin
      @(posedge clk); #1;
      cyc_d++;
      if (rst) rs_timer = 0;
      else if (o_reset_init_ena) rs_timer = 4;
      else if (rs_timer > 0) rs_timer--;
      i_resets_sent = (rs_timer == 1) || stray_rs;
      i_tx_ready = !rdy_zero && (cyc_d >= rdy_low_until) && (!rnd_rdy || ($urandom % 2 == 1));
    end
  end

  // Monitor.
  int mcyc = 0, anchor = 0, vstart = 0;
  bit prev_valid = 0, prev_ena = 0, prev_done = 0, await_rs = 0;
  always @(negedge clk) begin
    mcyc++;
    if (o_reset_init_ena) begin
      ena_cnt++; await_rs = 1;
      chk("ena_width", int'(prev_ena), 0);
    end
    if (i_resets_sent && await_rs) begin anchor = mcyc; await_rs = 0; end
    if (o_tx_valid) begin
      if (!prev_valid) vstart = mcyc;
      if (q.size() == 0 || q[0].is_done) chk("unexpected_tx", int'(o_tx_data), -1);
      else begin
        chk("tx_data", int'(o_tx_data), q[0].data);
        chk("tx_dc", int'(o_tx_dc), q[0].dc);
        if (i_tx_ready) begin
          chk("tx_latency", vstart - anchor, q[0].off);
          anchor = mcyc;
          void'(q.pop_front());
        end else stalls++;
      end
    end
    if (o_done) begin
      chk("done_width", int'(prev_done), 0);
      if (q.size() != 0 && q[0].is_done) begin
        chk("done_latency", mcyc - anchor, q[0].off);
        void'(q.pop_front());
      end else chk("unexpected_done", 1, 0);
    end
    prev_valid = o_tx_valid; prev_ena = o_reset_init_ena; prev_done = o_done;
  end

  task automatic start_seq();
    model_push();
    @(posedge clk); #1 i_start = 1;
    @(posedge clk); #1 i_start = 0;
    chk("busy_after_start", int'(o_busy), 1);
  endtask

  task automatic check_zero(string n);
    chk({n, "_busy"}, int'(o_busy), 0);
    chk({n, "_done"}, int'(o_done), 0);
    chk({n, "_ena"}, int'(o_reset_init_ena), 0);
    chk({n, "_valid"}, int'(o_tx_valid), 0);
    chk({n, "_data"}, int'(o_tx_data), 0);
    chk({n, "_dc"}, int'(o_tx_dc), 0);
    chk({n, "_addr"}, int'(o_rom_addr), 0);
  endtask

  task automatic do_reset(string n);
    #1 rst = 1;
    @(posedge clk); #1;
    q.delete(); rst = 0;
    @(negedge clk);
    check_zero(n);
  endtask

  task automatic wait_idle(string n);
    bit ok = 0;
    for (int i = 0; i < 4000 && !ok; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !o_busy) ok = 1;
    end
    if (!ok) begin
      chk({n, "_timeout"}, 0, 1);
      @(posedge clk); do_reset({n, "_recover"});
    end
  endtask

  task automatic load_rom1();
    rom[0] = {2'b00, 8'h01}; rom[1] = {2'b10, 8'd2}; rom[2] = {2'b00, 8'h11};
    rom[3] = {2'b01, 8'hA5}; rom[4] = {2'b11, 8'h00};
    for (int a = 5; a < DEP; a++) rom[a] = {2'b00, 8'hEE};
  endtask

  task automatic run_full(string n);
    int e0;
    e0 = ena_cnt;
    start_seq();
    wait_idle(n);
    chk({n, "_ena_pulses"}, ena_cnt - e0, 1);
  endtask

  initial begin
    int e0, s0;
    bit got;
    rst = 1; i_start = 0;
    for (int a = 0; a < DEP; a++) rom[a] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1 rst = 0;

    // Basic ROM with ready tied high.
    load_rom1();
    run_full("rom1");

    // Ready held low for 10 cycles while 0x11 is presented.
    e0 = ena_cnt; s0 = stalls;
    start_seq();
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (o_tx_valid && i_tx_ready && o_tx_data == 8'h01) got = 1;
    end
    chk("saw_first_byte", int'(got), 1);
    rdy_low_until = cyc_d + 25;
    wait_idle("stall");
    chk("stall_cycles", stalls - s0, 10);
    chk("stall_ena_pulses", ena_cnt - e0, 1);

    // A zero-length delay, and a ROM with no END marker.
    rom[0] = {2'b10, 8'd0}; rom[1] = {2'b00, 8'h29}; rom[2] = {2'b11, 8'h00};
    run_full("dly0");
    for (int a = 0; a < DEP; a++) rom[a] = {2'b00, 8'(a)};
    run_full("noend");

    // Reset during RST_DLY, followed by a replay.
    load_rom1();
    start_seq();
    repeat (12) @(posedge clk);
    do_reset("rst_dly");
    repeat (5) @(negedge clk);
    chk("rst_dly_stays_idle", int'(o_busy), 0);
    run_full("replay1");

    // Reset during SEND with ready low, followed by a replay.
    rdy_zero = 1;
    start_seq();
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (o_tx_valid) got = 1;
    end
    chk("saw_send", int'(got), 1);
    @(posedge clk);
    do_reset("rst_send");
    rdy_zero = 0;
    repeat (5) @(negedge clk);
    chk("rst_send_stays_idle", int'(o_busy), 0);
    run_full("replay2");

    // A start pulse while busy, and a stray resets_sent pulse while idle.
    e0 = ena_cnt;
    start_seq();
    repeat (30) @(posedge clk);
    #1 i_start = 1;
    @(posedge clk); #1 i_start = 0;
    wait_idle("start_busy");
    chk("start_busy_ena", ena_cnt - e0, 1);
    @(posedge clk); #1 stray_rs = 1;
    @(posedge clk); #1 stray_rs = 0;
    repeat (6) @(negedge clk);
    chk("stray_rs_idle", int'(o_busy), 0);
    chk("stray_rs_ena", ena_cnt - e0, 1);

    // Random ROMs, with a random ready pattern on some runs.
    for (int r = 0; r < 12; r++) begin
      int k;
      for (int a = 0; a < DEP; a++) begin
        k = int'($urandom % 8);
        if (k < 3)      rom[a] = {2'b00, 8'($urandom)};
        else if (k < 5) rom[a] = {2'b01, 8'($urandom)};
        else if (k < 7) rom[a] = {2'b10, 8'($urandom % 4)};
        else            rom[a] = {2'b11, 8'($urandom)};
      end
      rnd_rdy = bit'($urandom % 2);
      run_full("random");
    end
    rnd_rdy = 0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
